// File: rtl/rr_burst_arbiter.sv
// rr_burst_arbiter
// Round-robin arbiter with a per-ownership burst quota. A requester keeps the
// grant while it requests, for at most MAX_BURST consecutive cycles. The
// rotation pointer then moves past it and the grant is handed on at the same
// edge, with no idle cycle in between. All outputs are registered.
module rr_burst_arbiter #(
    parameter int N         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 gnt_valid
);

    localparam int          IW   = $clog2(N);
    localparam int          CW   = $clog2(MAX_BURST + 1);
    localparam int unsigned NU   = N;
    localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t         r_state,  w_state_n;
    logic [IW-1:0]  r_owner,  w_owner_n;
    logic [IW-1:0]  r_ptr,    w_ptr_n;
    logic [CW-1:0]  r_cnt,    w_cnt_n;
    logic [N-1:0]   r_gnt,    w_gnt_n;
    logic [IW-1:0]  r_gnt_id, w_gnt_id_n;
    logic           r_gnt_valid, w_gnt_valid_n;
    logic [IW-1:0]  w_owner_inc;

    // Rotated fixed-priority search: the first requesting index at or after p,
    // wrapping from N-1 back to 0. The request vector is rotated so that p
    // lands on bit 0, and the offset of the lowest set bit is added back to p.
    function automatic logic [IW-1:0] f_sel(input logic [N-1:0] r,
                                            input logic [IW-1:0] p);
        logic [N-1:0] rot;
        logic         found;
        int unsigned  off;
        int unsigned  sum;
        rot   = (r >> p) | (r << (NU - int'(p)));
        found = 1'b0;
        off   = 0;
        for (int unsigned k = 0; k < NU; k++) begin
            if (!found && rot[0]) begin
                found = 1'b1;
                off   = k;
            end
            rot = rot >> 1;
        end
        sum = int'(p) + off;
        if (sum >= NU) begin
            sum = sum - NU;
        end
        return IW'(sum);
    endfunction

    // The owner index plus one, wrapping to 0 so that the result never reaches N.
    assign w_owner_inc = (r_owner == IW'(N - 1)) ? '0 : r_owner + 1'b1;

    // Next-state logic: take a grant from idle, hold the burst, or release and hand on
    always_comb begin
        w_state_n     = r_state;
        w_owner_n     = r_owner;
        w_ptr_n       = r_ptr;
        w_cnt_n       = r_cnt;
        w_gnt_n       = '0;
        w_gnt_id_n    = '0;
        w_gnt_valid_n = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_owner_n = f_sel(req, r_ptr);
                    w_cnt_n   = CW'(1);
                    w_state_n = S_GRANT;
                end
            end
            S_GRANT: begin
                if (req[r_owner] && (r_cnt < MAXC)) begin
                    w_cnt_n = r_cnt + 1'b1;
                end else begin
                    // The search starts just past the owner, so a still-requesting
                    // owner whose quota has run out ranks last among the requesters.
                    w_ptr_n = w_owner_inc;
                    if (|req) begin
                        w_owner_n = f_sel(req, w_owner_inc);
                        w_cnt_n   = CW'(1);
                    end else begin
                        w_owner_n = '0;
                        w_cnt_n   = '0;
                        w_state_n = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase

        if (w_state_n == S_GRANT) begin
            w_gnt_n       = N'(1) << w_owner_n;
            w_gnt_id_n    = w_owner_n;
            w_gnt_valid_n = 1'b1;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_owner     <= '0;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_gnt_valid <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_owner     <= w_owner_n;
            r_ptr       <= w_ptr_n;
            r_cnt       <= w_cnt_n;
            r_gnt       <= w_gnt_n;
            r_gnt_id    <= w_gnt_id_n;
            r_gnt_valid <= w_gnt_valid_n;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = r_gnt_valid;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Testbench for rr_burst_arbiter (N=4, MAX_BURST=3).
// The driver applies inputs at the falling edge, advances a behavioural model
// and queues the outputs expected after the next rising edge. The monitor
// takes each expectation from the queue and compares it after that edge.
module tb_rr_burst_arbiter;

    localparam int N  = 4;
    localparam int MB = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] gnt;
    logic [1:0]   gnt_id;
    logic         gnt_valid;

    rr_burst_arbiter #(.N(N), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] gnt;
        logic [1:0]   id;
        logic         v;
        logic [1:0]   ptr;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Model state: owner -1 means no grant; used counts grant cycles in this ownership
    int m_owner = -1;
    int m_ptr   = 0;
    int m_used  = 0;

    function automatic int pick(input logic [N-1:0] r, input int start);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (start + k) % N;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic drive(input logic r_v, input logic [N-1:0] q_v);
        exp_t e;
        @(negedge clk);
        rst = r_v;
        req = q_v;
        if (r_v) begin
            m_owner = -1;
            m_ptr   = 0;
            m_used  = 0;
        end else if (m_owner < 0) begin
            if (q_v != 0) begin
                m_owner = pick(q_v, m_ptr);
                m_used  = 1;
            end
        end else if (q_v[m_owner] && m_used < MB) begin
            m_used = m_used + 1;
        end else begin
            m_ptr = (m_owner + 1) % N;
            if (q_v != 0) begin
                m_owner = pick(q_v, m_ptr);
                m_used  = 1;
            end else begin
                m_owner = -1;
            end
        end
        e.gnt = (m_owner < 0) ? '0 : (N'(1) << m_owner);
        e.id  = (m_owner < 0) ? 2'd0 : 2'(m_owner);
        e.v   = (m_owner >= 0);
        e.ptr = 2'(m_ptr);
        q.push_back(e);
    endtask

    task automatic hold(input logic r_v, input logic [N-1:0] q_v, input int n);
        for (int i = 0; i < n; i++) drive(r_v, q_v);
    endtask

    // Monitor: compare the DUT outputs against the oldest pending expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_cmp++;
                if (gnt !== e.gnt) begin
                    n_bad++;
                    $display("FAIL gnt t=%0t got=%b want=%b", $time, gnt, e.gnt);
                end
                n_cmp++;
                if (gnt_id !== e.id) begin
                    n_bad++;
                    $display("FAIL gnt_id t=%0t got=%0d want=%0d", $time, gnt_id, e.id);
                end
                n_cmp++;
                if (gnt_valid !== e.v) begin
                    n_bad++;
                    $display("FAIL gnt_valid t=%0t got=%b want=%b", $time, gnt_valid, e.v);
                end
                n_cmp++;
                if (dut.r_ptr !== e.ptr) begin
                    n_bad++;
                    $display("FAIL ptr t=%0t got=%0d want=%0d", $time, dut.r_ptr, e.ptr);
                end
            end
        end
    end

    initial begin
        int budget;
        logic [N-1:0] pat;
        // Reset with every request high, then full load through a complete rotation
        hold(1'b1, 4'b1111, 3);
        hold(1'b0, 4'b1111, 14);
        hold(1'b0, 4'b0000, 2);
        // Single pulse from idle after a fresh reset
        hold(1'b1, 4'b0000, 1);
        hold(1'b0, 4'b0010, 1);
        hold(1'b0, 4'b0000, 3);
        // Lone long requester, re-granted through quota expiries
        hold(1'b0, 4'b0100, 7);
        hold(1'b0, 4'b0000, 2);
        // Owner 3 drops while 0 requests; bit 2 arrives mid-burst and waits
        hold(1'b0, 4'b1000, 2);
        hold(1'b0, 4'b0001, 1);
        hold(1'b0, 4'b0101, 6);
        hold(1'b0, 4'b0000, 2);
        // Reset in the middle of a burst, then competing requests
        hold(1'b1, 4'b0000, 1);
        hold(1'b0, 4'b0010, 2);
        hold(1'b1, 4'b0010, 1);
        hold(1'b0, 4'b0110, 5);
        // Randomised traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            pat = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) pat = '0;
            hold(($urandom_range(0, 63) == 0), pat, $urandom_range(1, 6));
        end
        hold(1'b0, 4'b0000, 2);
        budget = 10;
        while (q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #2;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_burst_arbiter.md
RR_BURST_ARBITER -- requirements
Module: rr_burst_arbiter

Interface
REQ-001 Parameter N, default 8: number of requesters, legal range N >= 2.
REQ-002 Parameter MAX_BURST, default 4: maximum consecutive grant cycles per ownership, legal range MAX_BURST >= 1.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req  input  N  per-requester request, level-sensitive; bit 0 = requester 0.
REQ-006 gnt  output  N  registered grant, one-hot or zero.
REQ-007 gnt_id  output  $clog2(N)  binary index of the current owner; 0 when gnt_valid=0.
REQ-008 gnt_valid  output  1  high iff gnt is nonzero.

Function
REQ-009 The block SHALL hold state: state {IDLE, GRANT}, owner index, rotating pointer ptr ($clog2(N) bits), burst counter cnt ($clog2(MAX_BURST+1) bits).
REQ-010 The select function sel(r, p) SHALL return the first index i with r[i]=1, searching p, p+1, ... N-1, 0, ... p-1 (wrap-around), i.e. a rotated fixed-priority search starting at p.
REQ-011 In IDLE with req=0, all outputs SHALL remain zero and ptr SHALL remain unchanged.
REQ-012 In IDLE with req!=0, at the next edge: owner <= sel(req, ptr); gnt <= one-hot(owner); cnt <= 1; state <= GRANT.
REQ-013 Latency from a req bit rising in an idle arbiter to the matching gnt bit SHALL be exactly 1 cycle.
REQ-014 In GRANT with req[owner]=1 and cnt < MAX_BURST, the grant SHALL be held and cnt SHALL be incremented.
REQ-015 In GRANT with req[owner]=0 or cnt = MAX_BURST, a release SHALL occur: ptr <= (owner+1) mod N.
REQ-016 On release with req!=0, the arbiter SHALL grant sel(req, (owner+1) mod N) at the same edge, with cnt <= 1 and no idle bubble.
REQ-017 On release with req=0, the arbiter SHALL set gnt <= 0 and state <= IDLE.
REQ-018 A quota-expired owner still requesting SHALL be re-granted only if no other requester is active (it ranks last after rotation); a re-grant restarts cnt at 1, so gnt stays continuously high.
REQ-019 A requester dropping req SHALL observe its gnt fall 1 cycle later, because gnt is registered; the grant in that lag cycle is legal.
REQ-020 gnt SHALL never have more than one bit set, and gnt, gnt_id and gnt_valid SHALL be mutually consistent every cycle.
REQ-021 Changes on non-owner req bits during GRANT SHALL NOT affect the current ownership.
REQ-022 The pointer SHALL wrap from N-1 to 0; N need not be a power of two, and ptr SHALL never hold a value >= N.

Reset
REQ-023 With rst=1 at an edge: state <= IDLE; gnt <= 0; gnt_id <= 0; gnt_valid <= 0; ptr <= 0; cnt <= 0; req SHALL be ignored that cycle.
REQ-024 Reset asserted mid-burst SHALL drop the grant at that same edge; the first grant after reset SHALL use ptr=0.

Verification (N=4, MAX_BURST=3)
REQ-025 Reset: hold rst=1 with req=1111 -> gnt=0000, gnt_valid=0; release rst -> next cycle gnt=0001.
REQ-026 Full load: req=1111 held -> gnt sequence 0001 x3, 0010 x3, 0100 x3, 1000 x3, then 0001 again (wrap), with no bubble cycles.
REQ-027 Single pulse: req=0010 for one cycle from idle -> gnt=0010 for exactly one cycle, then 0000; ptr=2.
REQ-028 Lone long requester: req=0100 held 7 cycles -> gnt=0100 continuous through quota expiries; ptr=3 after the first expiry.
REQ-029 Wrap and early release: owner 3 drops req while req=0001 -> next gnt=0001, gnt_id=0; a later request on bit 2 arriving mid-burst waits until the release.
REQ-030 Mid-burst reset: assert rst during cycle 2 of the 0010 burst -> gnt=0000 at that edge; after rst falls with req=0110 -> gnt=0010.
